// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: FSM states, requester IDs
// and the burst-counter helper.
package dmem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_e;

   localparam logic REQ_M0  = 1'b0;
   localparam logic REQ_M1  = 1'b1;
   localparam int   COUNT_W = 4;

   function automatic logic [COUNT_W-1:0] count_sat_inc(input logic [COUNT_W-1:0] value);
      logic [COUNT_W-1:0] result;
      if (value == 4'hF) begin
         result = 4'hF;
      end else begin
         result = value + 4'd1;
      end
      return result;
   endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin pick: the owner keeps priority until its burst is
// used up, otherwise the requester that did not win last goes next.
module rr_pick2
   import dmem_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       owner,
   input  logic       count_at_max,
   input  logic       last_winner,
   output logic       winner,
   output logic       valid
);

   // winner selection from the request pattern
   always_comb begin
      winner = last_winner;
      valid  = 1'b0;
      case (req)
         2'b00: begin
            winner = last_winner;
            valid  = 1'b0;
         end
         2'b01: begin
            winner = REQ_M0;
            valid  = 1'b1;
         end
         2'b10: begin
            winner = REQ_M1;
            valid  = 1'b1;
         end
         2'b11: begin
            valid = 1'b1;
            if (count_at_max) begin
               winner = ~last_winner;
            end else begin
               winner = owner;
            end
         end
         default: begin
            winner = last_winner;
            valid  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates two requesters onto one single-port data memory with bounded
// round-robin bursts, tagging the one-cycle-late read data to its issuer.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int MEMORY_DEPTH = 64,
   parameter int MAX_BURST    = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  m0_req,
   input  logic                  m0_we,
   input  logic [DATA_WIDTH-1:0] m0_addr,
   input  logic [DATA_WIDTH-1:0] m0_wdata,
   output logic                  m0_gnt,
   output logic                  m0_rvalid,
   output logic [DATA_WIDTH-1:0] m0_rdata,
   input  logic                  m1_req,
   input  logic                  m1_we,
   input  logic [DATA_WIDTH-1:0] m1_addr,
   input  logic [DATA_WIDTH-1:0] m1_wdata,
   output logic                  m1_gnt,
   output logic                  m1_rvalid,
   output logic [DATA_WIDTH-1:0] m1_rdata,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  err_oor
);

   localparam logic [DATA_WIDTH-1:0] DEPTH_LIMIT = DATA_WIDTH'(MEMORY_DEPTH);
   localparam logic [COUNT_W-1:0]    BURST_MAX   = COUNT_W'(MAX_BURST);

   arb_state_e             state_r;
   arb_state_e             state_nxt_s;
   logic [COUNT_W-1:0]     count_r;
   logic [COUNT_W-1:0]     count_nxt_s;
   logic                   last_winner_r;
   logic                   last_winner_nxt_s;
   logic [DATA_WIDTH-1:0]  hold_addr_r;
   logic                   rd_pend_r;
   logic                   tag_req_r;
   logic                   tag_inrange_r;
   logic                   err_oor_r;

   logic                   owner_s;
   logic                   count_at_max_s;
   logic                   winner_s;
   logic                   valid_s;
   logic                   gnt_s;
   logic                   sel_we_s;
   logic [DATA_WIDTH-1:0]  sel_addr_s;
   logic [DATA_WIDTH-1:0]  sel_wdata_s;
   logic                   in_range_s;
   logic [DATA_WIDTH-1:0]  rdata_s;

   // current owner and burst exhaustion; IDLE behaves as an exhausted burst so ties go to the non-last winner
   always_comb begin
      owner_s        = last_winner_r;
      count_at_max_s = 1'b1;
      case (state_r)
         IDLE: begin
            owner_s        = last_winner_r;
            count_at_max_s = 1'b1;
         end
         OWN0: begin
            owner_s        = REQ_M0;
            count_at_max_s = (count_r == BURST_MAX);
         end
         OWN1: begin
            owner_s        = REQ_M1;
            count_at_max_s = (count_r == BURST_MAX);
         end
         default: begin
            owner_s        = last_winner_r;
            count_at_max_s = 1'b1;
         end
      endcase
   end

   rr_pick2 u_pick (
      .req          ({m1_req, m0_req}),
      .owner        (owner_s),
      .count_at_max (count_at_max_s),
      .last_winner  (last_winner_r),
      .winner       (winner_s),
      .valid        (valid_s)
   );

   // granted requester's access, with reset blocking any grant or write
   always_comb begin
      gnt_s = valid_s & ~reset;
      if (winner_s == REQ_M1) begin
         sel_we_s    = m1_we;
         sel_addr_s  = m1_addr;
         sel_wdata_s = m1_wdata;
      end else begin
         sel_we_s    = m0_we;
         sel_addr_s  = m0_addr;
         sel_wdata_s = m0_wdata;
      end
      in_range_s = (sel_addr_s < DEPTH_LIMIT);
   end

   // next-state, burst count and last-winner pointer
   always_comb begin
      state_nxt_s       = state_r;
      count_nxt_s       = count_r;
      last_winner_nxt_s = last_winner_r;
      if (valid_s) begin
         state_nxt_s       = (winner_s == REQ_M1) ? OWN1 : OWN0;
         last_winner_nxt_s = winner_s;
         if ((state_r != IDLE) && (winner_s == owner_s)) begin
            count_nxt_s = count_sat_inc(count_r);
         end else begin
            count_nxt_s = 4'd1;
         end
      end else begin
         state_nxt_s       = IDLE;
         count_nxt_s       = 4'd0;
         last_winner_nxt_s = last_winner_r;
      end
   end

   // memory-side drive; the held address keeps read data stable while idle
   always_comb begin
      mem_we    = gnt_s & sel_we_s & in_range_s;
      mem_wdata = '0;
      if (gnt_s) begin
         mem_addr  = sel_addr_s;
         mem_wdata = sel_wdata_s;
      end else if (reset) begin
         mem_addr = '0;
      end else begin
         mem_addr = hold_addr_r;
      end
   end

   // requester-side outputs; out-of-range reads return zeros
   always_comb begin
      m0_gnt    = gnt_s & (winner_s == REQ_M0);
      m1_gnt    = gnt_s & (winner_s == REQ_M1);
      if (tag_inrange_r) begin
         rdata_s = mem_rdata;
      end else begin
         rdata_s = '0;
      end
      m0_rdata  = rdata_s;
      m1_rdata  = rdata_s;
      m0_rvalid = rd_pend_r & ~reset & (tag_req_r == REQ_M0);
      m1_rvalid = rd_pend_r & ~reset & (tag_req_r == REQ_M1);
      err_oor   = err_oor_r;
   end

   // arbiter state, held address, read tag and sticky error
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r       <= IDLE;
         count_r       <= 4'd0;
         last_winner_r <= REQ_M1;
         hold_addr_r   <= '0;
         rd_pend_r     <= 1'b0;
         tag_req_r     <= REQ_M0;
         tag_inrange_r <= 1'b0;
         err_oor_r     <= 1'b0;
      end else begin
         state_r       <= state_nxt_s;
         count_r       <= count_nxt_s;
         last_winner_r <= last_winner_nxt_s;
         if (gnt_s) begin
            hold_addr_r <= sel_addr_s;
         end else begin
            hold_addr_r <= hold_addr_r;
         end
         rd_pend_r     <= gnt_s & ~sel_we_s;
         tag_req_r     <= winner_s;
         tag_inrange_r <= in_range_s;
         err_oor_r     <= err_oor_r | (gnt_s & ~in_range_s);
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a behavioural registered-address memory,
// grant-pattern checks and queued expected read returns.
module tb_dmem_arbiter;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          m0_req, m0_we, m1_req, m1_we;
   logic [DW-1:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
   logic [DW-1:0] m0_rdata, m1_rdata;
   logic          mem_we;
   logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;
   logic          err_oor;

   typedef struct packed {
      logic          id;
      logic [DW-1:0] data;
   } rd_exp_t;

   rd_exp_t       sb_q[$];
   logic [DW-1:0] ref_mem [0:63];
   logic [DW-1:0] mem_array [0:63];
   logic [5:0]    mem_addr_q;
   logic          g0, g1, we_seen;
   int            pass_cnt = 0;
   int            check_cnt = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.DATA_WIDTH(DW), .MEMORY_DEPTH(64), .MAX_BURST(4)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .err_oor(err_oor)
   );

   // single-port memory: synchronous write, registered read address
   always @(posedge clk) begin
      if (mem_we) mem_array[mem_addr[5:0]] <= mem_wdata;
      mem_addr_q <= mem_addr[5:0];
   end
   assign mem_rdata = mem_array[mem_addr_q];

   task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      check_cnt++;
      if (obs === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // one request cycle; granted reads push their expected return
   task automatic drive(input logic r0, input logic w0, input logic [DW-1:0] a0, input logic [DW-1:0] d0,
                        input logic r1, input logic w1, input logic [DW-1:0] a1, input logic [DW-1:0] d1,
                        input logic push);
      rd_exp_t e;
      m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
      m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
      @(negedge clk);
      g0 = m0_gnt;
      g1 = m1_gnt;
      we_seen = mem_we;
      if (g0) begin
         if (!w0 && push) begin
            e.id = 1'b0;
            e.data = (a0 < 64) ? ref_mem[a0[5:0]] : '0;
            sb_q.push_back(e);
         end else if (w0 && a0 < 64) begin
            ref_mem[a0[5:0]] = d0;
         end
      end
      if (g1) begin
         if (!w1 && push) begin
            e.id = 1'b1;
            e.data = (a1 < 64) ? ref_mem[a1[5:0]] : '0;
            sb_q.push_back(e);
         end else if (w1 && a1 < 64) begin
            ref_mem[a1[5:0]] = d1;
         end
      end
      @(posedge clk);
      #1;
      m0_req = 1'b0;
      m1_req = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // read-return checker driven by the scoreboard queue
   always @(negedge clk) begin
      rd_exp_t e;
      if (!reset) begin
         if (m0_rvalid && m1_rvalid) begin
            check_val("rvalid_both", 32'd1, 32'd0);
         end else if (m0_rvalid || m1_rvalid) begin
            if (sb_q.size() == 0) begin
               check_val("rvalid_unexpected", 32'd1, 32'd0);
            end else begin
               e = sb_q.pop_front();
               check_val("rd_id", 32'(m1_rvalid), 32'(e.id));
               check_val("rd_data", m1_rvalid ? m1_rdata : m0_rdata, e.data);
            end
         end
      end
   end

   initial begin
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'd7; m0_wdata = 32'hAAAA_AAAA;
      m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'd0; m1_wdata = 32'd0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_val("rst_m0_gnt", 32'(m0_gnt), 32'd0);
      check_val("rst_mem_we", 32'(mem_we), 32'd0);
      check_val("rst_mem_addr", mem_addr, 32'd0);
      check_val("rst_err_oor", 32'(err_oor), 32'd0);
      check_val("rst_rvalid", 32'({m0_rvalid, m1_rvalid}), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      m0_req = 1'b0;

      // write then read back on m0
      drive(1'b1, 1'b1, 32'd5, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
      check_val("t1_wr_gnt", 32'(g0), 32'd1);
      drive(1'b1, 1'b0, 32'd5, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
      check_val("t1_rd_gnt", 32'(g0), 32'd1);
      idle(2);

      // ties from IDLE follow the last-winner pointer
      do_reset();
      drive(1'b1, 1'b0, 32'd5, 32'd0, 1'b1, 1'b0, 32'd5, 32'd0, 1'b1);
      check_val("t2_tie0_g", 32'({g1, g0}), 32'b01);
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd5, 32'd0, 1'b1);
      check_val("t2_m1_next", 32'(g1), 32'd1);
      idle(1);
      drive(1'b1, 1'b0, 32'd5, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
      check_val("t2_m0_solo", 32'(g0), 32'd1);
      idle(1);
      drive(1'b1, 1'b0, 32'd5, 32'd0, 1'b1, 1'b0, 32'd5, 32'd0, 1'b1);
      check_val("t2_tie1_g", 32'({g1, g0}), 32'b10);
      drive(1'b1, 1'b0, 32'd5, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
      check_val("t2_m0_drain", 32'(g0), 32'd1);
      idle(2);

      // bounded bursts under contention, uncapped when alone
      do_reset();
      for (int i = 0; i < 12; i++) begin
         drive(1'b1, 1'b0, 32'd5, 32'd0, 1'b1, 1'b0, 32'd5, 32'd0, 1'b1);
         check_val($sformatf("t3_burst%0d", i), 32'({g1, g0}), (((i / 4) % 2) == 0) ? 32'b01 : 32'b10);
      end
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd5, 32'd0, 1'b1);
         check_val($sformatf("t3_m1solo%0d", i), 32'(g1), 32'd1);
      end
      idle(2);

      // out-of-range accesses
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'd0, 32'h0000_1234, 1'b1);
      check_val("t4_wr0_gnt", 32'(g1), 32'd1);
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd70, 32'd0, 1'b1);
      check_val("t4_oor_rd_gnt", 32'(g1), 32'd1);
      check_val("t4_oor_rd_we", 32'(we_seen), 32'd0);
      idle(1);
      check_val("t4_err_set", 32'(err_oor), 32'd1);
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'd64, 32'hFFFF_0000, 1'b1);
      check_val("t4_oor_wr_gnt", 32'(g1), 32'd1);
      check_val("t4_oor_wr_we", 32'(we_seen), 32'd0);
      idle(10);
      check_val("t4_err_sticky", 32'(err_oor), 32'd1);
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
      idle(2);

      // reset right after a granted read drops the pending return
      drive(1'b1, 1'b0, 32'd5, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      check_val("t5_rd_gnt", 32'(g0), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check_val("t5_rvalid_drop", 32'({m0_rvalid, m1_rvalid}), 32'd0);
      check_val("t5_mem_we", 32'(mem_we), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check_val("t5_err_clr", 32'(err_oor), 32'd0);
      check_val("t5_no_rvalid", 32'({m0_rvalid, m1_rvalid}), 32'd0);
      @(posedge clk);
      #1;
      drive(1'b1, 1'b0, 32'd5, 32'd0, 1'b1, 1'b0, 32'd5, 32'd0, 1'b1);
      check_val("t5_tie_m0", 32'({g1, g0}), 32'b01);
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd5, 32'd0, 1'b1);
      idle(2);

      // write on m0 then immediate read on m1 of the same word
      drive(1'b1, 1'b1, 32'd3, 32'h0000_0001, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
      check_val("t6_wr_gnt", 32'(g0), 32'd1);
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd3, 32'd0, 1'b1);
      check_val("t6_rd_gnt", 32'(g1), 32'd1);
      idle(3);

      check_val("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares one single-port data memory between two requesters: m0 (CPU load/store stage) and m1 (debug/DMA loader).
- The memory writes synchronously and reads with one cycle of latency through a registered address.
- The arbiter grants at most one access per cycle and returns read data tagged to the requester that issued the read.
- Ownership is round-robin, with a bounded burst so neither requester can starve the other.

Parameters:
- DATA_WIDTH, 32: width of data and address buses.
- MEMORY_DEPTH, 64: number of words in the attached memory. Valid addresses are 0..MEMORY_DEPTH-1.
- MAX_BURST, 4: maximum consecutive grants to one requester while the other is requesting. Must be 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- m0_req  in  1  m0 access request.
- m0_we  in  1  m0 write (1) / read (0).
- m0_addr  in  DATA_WIDTH  m0 word address.
- m0_wdata  in  DATA_WIDTH  m0 write data.
- m0_gnt  out  1  m0 access accepted this cycle.
- m0_rvalid  out  1  m0 read data valid.
- m0_rdata  out  DATA_WIDTH  m0 read data.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as m0, for m1.
- mem_we  out  1  to memory write enable.
- mem_addr  out  DATA_WIDTH  to memory address.
- mem_wdata  out  DATA_WIDTH  to memory write data.
- mem_rdata  in  DATA_WIDTH  from memory read data (valid one cycle after address).
- err_oor  out  1  sticky flag: an out-of-range access was granted.

Behaviour:
- Reset values: all gnt/rvalid = 0, err_oor = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0. FSM goes to IDLE, burst count = 0, last-winner pointer = m1, so m0 wins the first tie.
- Grant timing:
  - Grant is combinational in the request cycle. mX_gnt=1 means the access is presented on mem_* that same cycle.
  - A requester holds req, we, addr and wdata stable until it sees gnt.
- FSM states: IDLE, OWN0, OWN1.
  - IDLE: no request -> stay. One request -> grant it and go to OWNx with count=1. Both requesting -> grant the requester that is not the last winner.
  - OWNx, owner requesting, and (other idle or count<MAX_BURST): grant the owner, count+1 (saturating).
  - OWNx, other requesting and (owner idle or count==MAX_BURST): grant the other, move to OWNy, count=1.
  - OWNx, no requests: go to IDLE. The count clears and the last-winner pointer is kept.
- Memory drive:
  - mem_we = granted & we & in_range.
  - mem_addr and mem_wdata come from the granted requester.
  - When nothing is granted, mem_addr holds its last granted value from an internal register, so the read data stays stable. mem_we=0.
- Read return:
  - A granted read sets the matching mX_rvalid in the next cycle, for exactly one cycle.
  - mX_rdata = mem_rdata when in range. A tag register records requester and range.
  - Both rdata ports carry the value; only the matching rvalid is asserted.
- Out of range (addr >= MEMORY_DEPTH):
  - The access is still granted.
  - A write is suppressed (mem_we=0).
  - A read returns all zeros with rvalid.
  - err_oor sets and stays set until reset.
- Back-to-back grants: a read in cycle N and any grant in cycle N+1 are both legal. The rvalid for N appears in N+1, concurrent with the new grant.
- Write followed by read of the same address in the next cycle returns the new data.
- gnt never depends on rvalid; no backpressure on read return.
- Reset mid-operation: a pending rvalid is dropped, the FSM goes to IDLE, and no memory write occurs in the reset cycle.
- Widths: the burst counter is 4 bits. The range compare is on the full DATA_WIDTH address.

Decomposition:
- Shared constants file holds:
  - FSM state encodings IDLE=2'd0, OWN0=2'd1, OWN1=2'd2.
  - Requester IDs REQ_M0=1'b0, REQ_M1=1'b1.
- One sub-module: rr_pick2. It is combinational: inputs req[1:0], owner, count_at_max, last_winner; outputs winner and valid.
- The FSM, registers and mux stay in dmem_arbiter.

Test Plan:
1. Reset, then m0 writes 0xDEADBEEF to addr 5, then m0 reads addr 5 -> m0_gnt in both cycles; m0_rvalid one cycle after the read grant with rdata=0xDEADBEEF; m1_rvalid=0.
2. Both request from IDLE after reset -> m0 granted first, then m1. Repeat the tie from IDLE -> winner alternates with the last-winner pointer.
3. m0 requests continuously, m1 requests continuously, MAX_BURST=4 -> grant pattern m0×4, m1×4, m0×4. Only m1 requests -> m1 granted every cycle with no cap.
4. m1 reads addr 70 with depth 64 -> m1_gnt=1, mem_we=0, m1_rvalid next cycle with rdata=0, err_oor=1 and still 1 ten cycles later. m1 writes addr 64 -> memory contents unchanged.
5. m0 read granted in cycle N, reset asserted in cycle N+1 -> m0_rvalid=0 in N+1, state IDLE, err_oor=0, m0 wins the next tie.
6. m0 writes 0x1 to addr 3 in cycle N, m1 reads addr 3 in cycle N+1 -> m1_rdata=0x1 in N+2, with no stale data.
